// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped 8N1 UART transmitter with TX FIFO and baud divider
module uart_tx_mmio #(
  parameter int FIFO_DEPTH   = 16,
  parameter int BAUD_DIV_RST = 651
) (
  input  logic        CLK75,
  input  logic        RST,
  input  logic        SEL,
  input  logic        WE,
  input  logic        RE,
  input  logic [29:0] MADDR,
  input  logic [31:0] MDATAO,
  input  logic [3:0]  MWSTB,
  output logic [31:0] RDATA,
  output logic        TXD
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [1:0]    reg_addr;
  logic          wr_acc, rd_acc;
  logic [15:0]   baud_div;
  logic [15:0]   bit_load;
  logic          overflow;
  logic [7:0]    fifo_mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push_req, push, pop;
  logic [31:0]   status, rdata_next;

  state_t        state_q, state_d;
  logic [15:0]   timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_d;

  logic unused_bits;
  assign unused_bits = ^{MADDR[29:2], MDATAO[31:16], MWSTB[3:2]};

  assign reg_addr = MADDR[1:0];
  assign wr_acc   = SEL & WE;
  assign rd_acc   = SEL & RE;

  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign push_req = wr_acc && (reg_addr == 2'd0) && MWSTB[0];
  // A simultaneous pop frees the slot, so a push to a full FIFO still lands.
  assign push     = push_req && (!full || pop);

  // A divisor of zero behaves as one cycle per bit.
  assign bit_load = (baud_div == 16'd0) ? 16'd0 : baud_div - 16'd1;

  always_ff @(posedge CLK75) begin
    if (push) fifo_mem[wr_ptr] <= MDATAO[7:0];
  end

  always_ff @(posedge CLK75 or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (pop && !push) count <= count - CNT_ONE;
    end
  end

  always_ff @(posedge CLK75 or posedge RST) begin
    if (RST) begin
      overflow <= 1'b0;
      baud_div <= 16'(BAUD_DIV_RST);
    end else begin
      if (push_req && !push) overflow <= 1'b1;
      else if (wr_acc && (reg_addr == 2'd1) && MWSTB[0] && MDATAO[3]) overflow <= 1'b0;
      if (wr_acc && (reg_addr == 2'd2)) begin
        if (MWSTB[0]) baud_div[7:0]  <= MDATAO[7:0];
        if (MWSTB[1]) baud_div[15:8] <= MDATAO[15:8];
      end
    end
  end

  always_comb begin
    status          = '0;
    status[0]       = full;
    status[1]       = empty;
    status[2]       = (state_q != S_IDLE);
    status[3]       = overflow;
    status[CW+3:4]  = count;
  end

  always_comb begin
    rdata_next = '0;
    case (reg_addr)
      2'd1:    rdata_next = status;
      2'd2:    rdata_next = {16'd0, baud_div};
      default: rdata_next = '0;
    endcase
  end

  always_ff @(posedge CLK75 or posedge RST) begin
    if (RST)         RDATA <= '0;
    else if (rd_acc) RDATA <= rdata_next;
  end

  always_ff @(posedge CLK75 or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      TXD       <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      TXD       <= txd_d;
    end
  end

  // txd_d is the line level for the state being entered, keeping TXD a pure flop.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    txd_d     = TXD;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        txd_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr];
          timer_d = bit_load;
          state_d = S_START;
          txd_d   = 1'b0;
        end
      end
      S_START: begin
        if (timer_q == 16'd0) begin
          state_d   = S_DATA;
          timer_d   = bit_load;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_DATA: begin
        if (timer_q == 16'd0) begin
          timer_d = bit_load;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
            txd_d   = 1'b1;
          end else begin
            shift_d   = {1'b0, shift_q[7:1]};
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[1];
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      S_STOP: begin
        if (timer_q == 16'd0) begin
          if (!empty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr];
            timer_d = bit_load;
            state_d = S_START;
            txd_d   = 1'b0;
          end else begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
          end
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
endmodule
